// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/bubble sequencer for a 5-stage (F/D/E/M/W) pipeline. It drives
//   the pc register control (regF_*) and the D/E/M/W pipe-register controls.
//   After reset it runs a boot hold that keeps every bubble asserted, which pins pc
//   at its reset vector and drains the pipe. In RUN it resolves hazards with a fixed
//   priority: dmem wait, MDU occupancy, jump flush, load-use, imem wait.
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   decode_i_rs1/rs2(_ren)    source registers read by the instruction in D
//   execute_i_rd/is_load      destination and load flag of the instruction in E
//   execute_i_need_jump       E resolved a mispredicted branch/jump
//   execute_i_mdu_start       E holds a mul/div (level)
//   fetch_i_imem_ready        fetch data valid this cycle
//   memory_i_dmem_busy        M access not complete this cycle
//   regX_stall/regX_bubble    pipe-register controls (combinational)
//   stall_cycles              count of RUN cycles with regF_stall=1
module pipe_hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned MDU_LAT     = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       decode_i_rs1,
  input  logic [4:0]       decode_i_rs2,
  input  logic             decode_i_rs1_ren,
  input  logic             decode_i_rs2_ren,
  input  logic [4:0]       execute_i_rd,
  input  logic             execute_i_is_load,
  input  logic             execute_i_need_jump,
  input  logic             execute_i_mdu_start,
  input  logic             fetch_i_imem_ready,
  input  logic             memory_i_dmem_busy,
  output logic             regF_stall,
  output logic             regF_bubble,
  output logic             regD_stall,
  output logic             regD_bubble,
  output logic             regE_stall,
  output logic             regE_bubble,
  output logic             regM_stall,
  output logic             regM_bubble,
  output logic             regW_bubble,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES);
  localparam int unsigned MDU_W  = ($clog2(MDU_LAT) < 2) ? 2 : $clog2(MDU_LAT);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state,        state_nxt;
  logic [BOOT_W-1:0] boot_cnt,    boot_cnt_nxt;
  logic [MDU_W-1:0] mdu_cnt,      mdu_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt_nxt;

  logic mdu_hold;
  logic load_use;

  // A mul/div holds E on its first cycle and while more than one cycle remains.
  assign mdu_hold = ((mdu_cnt == '0) && execute_i_mdu_start) || (mdu_cnt > MDU_W'(1));

  // Load in E whose (non-x0) destination feeds an enabled source of D.
  assign load_use = execute_i_is_load && (execute_i_rd != 5'd0) &&
                    ((decode_i_rs1_ren && (decode_i_rs1 == execute_i_rd)) ||
                     (decode_i_rs2_ren && (decode_i_rs2 == execute_i_rd)));

  // State, boot/MDU counters and perf counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_BOOT;
      boot_cnt     <= BOOT_W'(BOOT_CYCLES - 1);
      mdu_cnt      <= '0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      boot_cnt     <= boot_cnt_nxt;
      mdu_cnt      <= mdu_cnt_nxt;
      stall_cycles <= stall_cnt_nxt;
    end
  end

  // Next state and pipe controls.
  always_comb begin
    state_nxt     = state;
    boot_cnt_nxt  = boot_cnt;
    mdu_cnt_nxt   = mdu_cnt;
    stall_cnt_nxt = stall_cycles;
    regF_stall    = 1'b0;
    regF_bubble   = 1'b0;
    regD_stall    = 1'b0;
    regD_bubble   = 1'b0;
    regE_stall    = 1'b0;
    regE_bubble   = 1'b0;
    regM_stall    = 1'b0;
    regM_bubble   = 1'b0;
    regW_bubble   = 1'b0;

    if (rst || (state == ST_BOOT)) begin
      regF_bubble = 1'b1;
      regD_bubble = 1'b1;
      regE_bubble = 1'b1;
      regM_bubble = 1'b1;
      regW_bubble = 1'b1;
    end

    if (state == ST_BOOT) begin
      mdu_cnt_nxt = '0;
      if (boot_cnt == '0) begin
        state_nxt = ST_RUN;
      end else begin
        boot_cnt_nxt = boot_cnt - BOOT_W'(1);
      end
    end else if (!rst) begin
      if (memory_i_dmem_busy) begin
        regF_stall  = 1'b1;
        regD_stall  = 1'b1;
        regE_stall  = 1'b1;
        regM_stall  = 1'b1;
        regW_bubble = 1'b1;
      end else if (mdu_hold) begin
        regF_stall  = 1'b1;
        regD_stall  = 1'b1;
        regE_stall  = 1'b1;
        regM_bubble = 1'b1;
      end else if (execute_i_need_jump) begin
        // pc is left free so it captures the jump target.
        regD_bubble = 1'b1;
        regE_bubble = 1'b1;
      end else if (load_use) begin
        regF_stall  = 1'b1;
        regD_stall  = 1'b1;
        regE_bubble = 1'b1;
      end else if (!fetch_i_imem_ready) begin
        regF_stall  = 1'b1;
        regD_bubble = 1'b1;
      end

      // MDU occupancy freezes while M stalls the whole pipe.
      if (!memory_i_dmem_busy) begin
        if ((mdu_cnt == '0) && execute_i_mdu_start) begin
          mdu_cnt_nxt = MDU_W'(MDU_LAT - 1);
        end else if (mdu_cnt != '0) begin
          mdu_cnt_nxt = mdu_cnt - MDU_W'(1);
        end
      end

      if (regF_stall) begin
        stall_cnt_nxt = stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Scoreboard bench: the driver computes the expected controls from a behavioural
//   model (boot cycles left, age of the mul/div in E, stall tally) and queues them;
//   a monitor pops and compares against the DUT on every falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned BOOT_CYCLES = 4;
  localparam int unsigned MDU_LAT     = 4;
  localparam int unsigned CNT_W       = 32;

  typedef struct packed {
    logic [8:0]       ctl;
    logic [CNT_W-1:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic ren1, ren2, is_load, need_jump, mdu_start, imem_ready, dmem_busy;
  logic f_s, f_b, d_s, d_b, e_s, e_b, m_s, m_b, w_b;
  logic [CNT_W-1:0] stall_cycles;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  int unsigned      boot_left;
  int unsigned      age;
  logic [CNT_W-1:0] m_sc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .BOOT_CYCLES(BOOT_CYCLES), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2),
    .decode_i_rs1_ren(ren1), .decode_i_rs2_ren(ren2),
    .execute_i_rd(rd), .execute_i_is_load(is_load),
    .execute_i_need_jump(need_jump), .execute_i_mdu_start(mdu_start),
    .fetch_i_imem_ready(imem_ready), .memory_i_dmem_busy(dmem_busy),
    .regF_stall(f_s), .regF_bubble(f_b),
    .regD_stall(d_s), .regD_bubble(d_b),
    .regE_stall(e_s), .regE_bubble(e_b),
    .regM_stall(m_s), .regM_bubble(m_b),
    .regW_bubble(w_b), .stall_cycles(stall_cycles)
  );

  // Expected controls, order {F_s,F_b,D_s,D_b,E_s,E_b,M_s,M_b,W_b}.
  function automatic logic [8:0] model_ctl();
    logic hold, lu;
    if (rst || boot_left > 0) return 9'b010101011;
    hold = (age == 0 && mdu_start) || (age >= 1 && age < MDU_LAT - 1);
    lu   = is_load && rd != 0 && ((ren1 && rs1 == rd) || (ren2 && rs2 == rd));
    if (dmem_busy)       return 9'b101010101;
    if (hold)            return 9'b101010010;
    if (need_jump)       return 9'b000101000;
    if (lu)              return 9'b101001000;
    if (!imem_ready)     return 9'b100100000;
    return 9'b000000000;
  endfunction

  // Advance the model across one rising edge.
  task automatic model_edge(input logic [8:0] ctl);
    if (rst) begin
      boot_left = BOOT_CYCLES;
      age       = 0;
      m_sc      = '0;
    end else if (boot_left > 0) begin
      boot_left = boot_left - 1;
    end else begin
      if (ctl[8]) m_sc = m_sc + 1'b1;
      if (!dmem_busy) begin
        if (age == 0) begin
          if (mdu_start) age = 1;
        end else if (age == MDU_LAT - 1) begin
          age = 0;
        end else begin
          age = age + 1;
        end
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    e.ctl = model_ctl();
    e.sc  = m_sc;
    q.push_back(e);
    @(posedge clk);
    #1;
    model_edge(e.ctl);
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; ren1 = 1'b0; ren2 = 1'b0;
    is_load = 1'b0; need_jump = 1'b0; mdu_start = 1'b0;
    imem_ready = 1'b1; dmem_busy = 1'b0;
  endtask

  // Monitor: compare queued expectations on the falling edge.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {f_s, f_b, d_s, d_b, e_s, e_b, m_s, m_b, w_b};
        n_cmp++;
        if (act !== e.ctl) begin
          n_bad++;
          $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.ctl);
        end
        n_cmp++;
        if (stall_cycles !== e.sc) begin
          n_bad++;
          $display("FAIL stall_cycles t=%0t actual=%0d required=%0d", $time, stall_cycles, e.sc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    boot_left = BOOT_CYCLES; age = 0; m_sc = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (BOOT_CYCLES + 3) tick();

    // load-use on rs2, then same load to x0
    is_load = 1'b1; rd = 5'd5; rs2 = 5'd5; ren2 = 1'b1; tick();
    rd = 5'd0; rs2 = 5'd0; tick();
    idle(); tick();

    // back-to-back mul/div with start held
    mdu_start = 1'b1; repeat (2 * MDU_LAT) tick();
    idle(); tick();

    // jump hidden behind dmem wait, flushes once busy drops
    need_jump = 1'b1; dmem_busy = 1'b1; tick(); tick();
    dmem_busy = 1'b0; tick();
    idle(); tick();

    // every hazard at once
    dmem_busy = 1'b1; mdu_start = 1'b1; need_jump = 1'b1; is_load = 1'b1;
    rd = 5'd7; rs1 = 5'd7; ren1 = 1'b1; imem_ready = 1'b0;
    repeat (3) tick();
    idle(); tick();

    // reset while the mul/div is mid-flight
    mdu_start = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; mdu_start = 1'b0;
    repeat (BOOT_CYCLES + 3) tick();

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      rs1        = 5'($urandom_range(0, 3));
      rs2        = 5'($urandom_range(0, 3));
      rd         = 5'($urandom_range(0, 3));
      ren1       = 1'($urandom_range(0, 1));
      ren2       = 1'($urandom_range(0, 1));
      is_load    = ($urandom_range(0, 9) < 4);
      need_jump  = ($urandom_range(0, 9) < 2);
      mdu_start  = ($urandom_range(0, 9) < 3);
      imem_ready = ($urandom_range(0, 9) < 7);
      dmem_busy  = ($urandom_range(0, 9) < 2);
      tick();
    end

    idle(); rst = 1'b0;
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
